// File: rtl/cv32e40x_instr_aligner_pkg.sv
// Shared types and constants for the instruction aligner.
// One fetch-buffer entry is a fetched word plus its bus error flag.
package cv32e40x_instr_aligner_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_word_t;

    localparam int unsigned ALIGN_DEPTH_DEFAULT = 3;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/cv32e40x_instr_aligner_if.sv
// Fetch-response, redirect and aligned-instruction signals between the prefetcher, the aligner and ID.
// The slave modport is the aligner's view; the master modport is the view of the surrounding pipeline.
interface cv32e40x_instr_aligner_if;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        branch;
    logic [31:0] branch_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        instr_bus_err;

    modport slave (
        input  resp_valid, resp_data, resp_err, branch, branch_addr, instr_ready,
        output instr_valid, instr_data, instr_pc, instr_compressed, instr_bus_err
    );

    modport master (
        output resp_valid, resp_data, resp_err, branch, branch_addr, instr_ready,
        input  instr_valid, instr_data, instr_pc, instr_compressed, instr_bus_err
    );

endinterface

// File: rtl/cv32e40x_instr_aligner.sv
// Instruction aligner: buffers fetch words and presents one 16/32-bit instruction per cycle
// from any halfword boundary, together with its PC and bus error status.
module cv32e40x_instr_aligner
    import cv32e40x_instr_aligner_pkg::*;
#(
    parameter  int unsigned DEPTH = ALIGN_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    cv32e40x_instr_aligner_if.slave bus_if,
    output logic [CNT_W-1:0]        free_slots_o
);

    localparam int unsigned       PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(DEPTH - 1);

    fetch_word_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d, rptr_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic             offset_q, offset_d;
    logic             err_block_q, err_block_d;
    logic [31:0]      pc_q, pc_d;

    fetch_word_t      w0, w1;
    logic [15:0]      hw;
    logic             hw_c;
    logic             avail, err_sel;
    logic [31:0]      data_sel;
    logic             valid, accept, pop, push_en;
    logic             unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

    assign rptr_nxt    = ptr_inc(rptr_q);
    assign w0          = mem_q[rptr_q];
    assign w1          = mem_q[rptr_nxt];
    assign hw          = offset_q ? w0.data[31:16] : w0.data[15:0];
    assign hw_c        = is_compressed(hw);
    assign unused_bits = ^{w1.data[31:16], bus_if.branch_addr[0]};

    // An erroneous head word is reported as soon as it is present, even if the
    // instruction would also need the following word.
    always_comb begin
        avail    = 1'b0;
        err_sel  = 1'b0;
        data_sel = '0;
        if (count_q != '0) begin
            if (w0.err) begin
                avail   = 1'b1;
                err_sel = 1'b1;
            end else if (!offset_q) begin
                avail    = 1'b1;
                data_sel = hw_c ? {16'h0, hw} : w0.data;
            end else if (hw_c) begin
                avail    = 1'b1;
                data_sel = {16'h0, hw};
            end else if (count_q >= CNT_W'(2)) begin
                avail    = 1'b1;
                err_sel  = w1.err;
                data_sel = w1.err ? 32'h0 : {w1.data[15:0], hw};
            end
        end
    end

    assign valid   = avail & ~err_block_q & ~bus_if.branch;
    assign accept  = valid & bus_if.instr_ready;
    assign pop     = accept & (offset_q | ~hw_c);
    assign push_en = bus_if.resp_valid & ~bus_if.branch & ((count_q != DEPTH_C) | pop);

    assign bus_if.instr_valid      = valid;
    assign bus_if.instr_data       = valid ? data_sel : 32'h0;
    assign bus_if.instr_pc         = pc_q;
    assign bus_if.instr_compressed = valid & ~err_sel & hw_c;
    assign bus_if.instr_bus_err    = valid & err_sel;
    assign free_slots_o            = DEPTH_C - count_q;

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        offset_d    = offset_q;
        err_block_d = err_block_q;
        pc_d        = pc_q;
        if (bus_if.branch) begin
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            err_block_d = 1'b0;
            pc_d        = {bus_if.branch_addr[31:1], 1'b0};
            offset_d    = bus_if.branch_addr[1];
        end else begin
            if (push_en) wptr_d = ptr_inc(wptr_q);
            if (pop)     rptr_d = rptr_nxt;
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
            if (accept) begin
                pc_d     = pc_q + (hw_c ? 32'd2 : 32'd4);
                offset_d = offset_q ^ hw_c;
                if (err_sel) err_block_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            offset_q    <= 1'b0;
            err_block_q <= 1'b0;
            pc_q        <= '0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            offset_q    <= offset_d;
            err_block_q <= err_block_d;
            pc_q        <= pc_d;
        end
    end

    // When full, a push only lands together with a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_en) begin
            mem_q[wptr_q] <= '{data: bus_if.resp_data, err: bus_if.resp_err};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(bus_if.resp_valid && !bus_if.branch && count_q == DEPTH_C && !pop));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= DEPTH_C);

    a_stable_out: assert property (@(posedge clk) disable iff (rst)
        (bus_if.instr_valid && !bus_if.instr_ready && !bus_if.branch) |=>
        (bus_if.branch || $stable({bus_if.instr_valid, bus_if.instr_data, bus_if.instr_pc,
                                   bus_if.instr_compressed, bus_if.instr_bus_err})));

endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
// Directed bench for the instruction aligner: stimulus pushes expected instructions into a
// scoreboard queue, a monitor compares every accepted instruction against it.
module tb_cv32e40x_instr_aligner;

    logic       clk;
    logic       rst;
    logic [1:0] free_slots;

    cv32e40x_instr_aligner_if bus_if ();

    cv32e40x_instr_aligner dut (
        .clk          (clk),
        .rst          (rst),
        .bus_if       (bus_if),
        .free_slots_o (free_slots)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        c;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch_to(input logic [31:0] addr);
        bus_if.branch      = 1'b1;
        bus_if.branch_addr = addr;
        tick();
        bus_if.branch      = 1'b0;
    endtask

    task automatic push(input logic [31:0] data, input logic err);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_data  = data;
        bus_if.resp_err   = err;
        tick();
        bus_if.resp_valid = 1'b0;
        bus_if.resp_err   = 1'b0;
    endtask

    task automatic expect_instr(input logic [31:0] data, input logic [31:0] pc,
                                input logic c, input logic err);
        exp_t e;
        e.data = data;
        e.pc   = pc;
        e.c    = c;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus_if.instr_valid && bus_if.instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got data %h pc %h, expected none",
                         bus_if.instr_data, bus_if.instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("instr_data", bus_if.instr_data, e.data);
                chk("instr_pc", bus_if.instr_pc, e.pc);
                chk("instr_compressed", {31'h0, bus_if.instr_compressed}, {31'h0, e.c});
                chk("instr_bus_err", {31'h0, bus_if.instr_bus_err}, {31'h0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus_if.resp_valid  = 1'b0;
        bus_if.resp_data   = '0;
        bus_if.resp_err    = 1'b0;
        bus_if.branch      = 1'b0;
        bus_if.branch_addr = '0;
        bus_if.instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_valid", {31'h0, bus_if.instr_valid}, 32'h0);
        chk("rst_data", bus_if.instr_data, 32'h0);
        chk("rst_pc", bus_if.instr_pc, 32'h0);
        chk("rst_c", {31'h0, bus_if.instr_compressed}, 32'h0);
        chk("rst_err", {31'h0, bus_if.instr_bus_err}, 32'h0);
        chk("rst_free", {30'h0, free_slots}, 32'd3);

        // Aligned 32-bit instruction
        branch_to(32'h100);
        expect_instr(32'h00A00093, 32'h100, 1'b0, 1'b0);
        push(32'h00A00093, 1'b0);
        tick();
        chk("t1_free", {30'h0, free_slots}, 32'd3);
        chk("t1_pc", bus_if.instr_pc, 32'h104);
        chk("t1_valid", {31'h0, bus_if.instr_valid}, 32'h0);

        // Compressed instruction in the upper halfword
        branch_to(32'h102);
        expect_instr(32'h00004505, 32'h102, 1'b1, 1'b0);
        push(32'h45050001, 1'b0);
        tick();
        chk("t2_free", {30'h0, free_slots}, 32'd3);
        chk("t2_pc", bus_if.instr_pc, 32'h104);

        // 32-bit instruction straddling two words, followed by a compressed one
        branch_to(32'h106);
        push(32'h00931234, 1'b0);
        chk("t3_wait0", {31'h0, bus_if.instr_valid}, 32'h0);
        tick();
        chk("t3_wait1", {31'h0, bus_if.instr_valid}, 32'h0);
        expect_instr(32'h00A00093, 32'h106, 1'b0, 1'b0);
        expect_instr(32'h00005678, 32'h10A, 1'b1, 1'b0);
        push(32'h567800A0, 1'b0);
        tick();
        tick();
        chk("t3_free", {30'h0, free_slots}, 32'd3);
        chk("t3_pc", bus_if.instr_pc, 32'h10C);

        // Bus error blocks output until the next redirect
        branch_to(32'h200);
        expect_instr(32'h0, 32'h200, 1'b0, 1'b1);
        push(32'h00000013, 1'b1);
        push(32'h00000013, 1'b0);
        chk("t4_block0", {31'h0, bus_if.instr_valid}, 32'h0);
        push(32'h00000013, 1'b0);
        chk("t4_block1", {31'h0, bus_if.instr_valid}, 32'h0);
        chk("t4_free", {30'h0, free_slots}, 32'd1);
        branch_to(32'h300);
        chk("t4_br_free", {30'h0, free_slots}, 32'd3);
        chk("t4_br_pc", bus_if.instr_pc, 32'h300);
        expect_instr(32'h00000013, 32'h300, 1'b0, 1'b0);
        push(32'h00000013, 1'b0);
        tick();
        chk("t4_pc", bus_if.instr_pc, 32'h304);

        // Fill, then push and accept in the same cycle while full
        bus_if.instr_ready = 1'b0;
        branch_to(32'h400);
        expect_instr(32'h00100093, 32'h400, 1'b0, 1'b0);
        expect_instr(32'h00200113, 32'h404, 1'b0, 1'b0);
        expect_instr(32'h00300193, 32'h408, 1'b0, 1'b0);
        expect_instr(32'h00400213, 32'h40C, 1'b0, 1'b0);
        push(32'h00100093, 1'b0);
        push(32'h00200113, 1'b0);
        push(32'h00300193, 1'b0);
        chk("t5_full", {30'h0, free_slots}, 32'd0);
        chk("t5_valid", {31'h0, bus_if.instr_valid}, 32'h1);
        chk("t5_data", bus_if.instr_data, 32'h00100093);
        tick();
        bus_if.instr_ready = 1'b1;
        push(32'h00400213, 1'b0);
        chk("t5_still_full", {30'h0, free_slots}, 32'd0);
        chk("t5_pc1", bus_if.instr_pc, 32'h404);
        repeat (3) tick();
        chk("t5_drained", {30'h0, free_slots}, 32'd3);
        chk("t5_pc", bus_if.instr_pc, 32'h410);

        // Redirect with a simultaneous response and ready
        bus_if.instr_ready = 1'b0;
        branch_to(32'h500);
        push(32'h00100093, 1'b0);
        bus_if.branch      = 1'b1;
        bus_if.branch_addr = 32'h600;
        bus_if.resp_valid  = 1'b1;
        bus_if.resp_data   = 32'h00200113;
        bus_if.instr_ready = 1'b1;
        @(negedge clk);
        chk("t6_br_valid", {31'h0, bus_if.instr_valid}, 32'h0);
        tick();
        bus_if.branch     = 1'b0;
        bus_if.resp_valid = 1'b0;
        chk("t6_free", {30'h0, free_slots}, 32'd3);
        chk("t6_pc", bus_if.instr_pc, 32'h600);
        chk("t6_valid", {31'h0, bus_if.instr_valid}, 32'h0);
        expect_instr(32'h00300193, 32'h600, 1'b0, 1'b0);
        push(32'h00300193, 1'b0);
        tick();
        chk("t6_pc_next", bus_if.instr_pc, 32'h604);

        // Reset in the middle of operation
        bus_if.instr_ready = 1'b0;
        branch_to(32'h700);
        push(32'h00100093, 1'b0);
        chk("t7_pre_valid", {31'h0, bus_if.instr_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t7_valid", {31'h0, bus_if.instr_valid}, 32'h0);
        chk("t7_free", {30'h0, free_slots}, 32'd3);
        chk("t7_pc", bus_if.instr_pc, 32'h0);
        tick();
        rst = 1'b0;
        bus_if.instr_ready = 1'b1;
        repeat (3) tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
